// File: rtl/branch_target_predictor_pkg.sv
// -----------------------------------------------------------------------------
// btp_pkg
// Shared constants, width helpers and the BTB entry layout for the
// branch_target_predictor slice.
//   ctr_wnt(bits)  : weakly-not-taken reset value for a bits-wide counter
//   CTR_WNT        : that value for the default 2-bit counter (2'b01)
//   idx_w(entries) : index width of a power-of-two table
//   tag_w(x, n)    : BTB tag width for x-bit PCs and n entries (pc[1:0] dropped)
//   btb_entry_t    : {valid, tag, target, uncond} in the default 32-bit /
//                    32-entry layout; the top re-declares it with its own widths
// -----------------------------------------------------------------------------
package btp_pkg;

  function automatic int ctr_wnt(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  localparam int CTR_WNT = ctr_wnt(2);

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int xlen, input int entries);
    return xlen - $clog2(entries) - 2;
  endfunction

  localparam int DEF_XLEN  = 32;
  localparam int DEF_TAG_W = tag_w(32, 32);

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_XLEN-1:0]  target;
    logic                 uncond;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Next-value logic for one saturating up/down counter (no storage).
//   cur  : present counter value
//   inc  : 1 = count up, 0 = count down
//   en   : 0 passes cur through unchanged
//   next : updated value, clamped to 0 .. 2^CTR_BITS-1
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cur,
  input  logic                inc,
  input  logic                en,
  output logic [CTR_BITS-1:0] next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  always_comb begin
    next = cur;
    if (en) begin
      if (inc) begin
        if (cur != CTR_MAX) next = cur + 1'b1;
      end else begin
        if (cur != '0) next = cur - 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// -----------------------------------------------------------------------------
// branch_target_predictor
// Direct-mapped tagged BTB plus a gshare-indexed PHT of saturating counters.
// Lookup is combinational on fetch_pc; training happens at the clock edge
// when a resolved control-flow instruction arrives from EX.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   fetch_pc              : IF-stage PC to look up
//   pred_hit              : valid BTB entry with matching tag
//   pred_taken            : redirect fetch to pred_target
//   pred_target           : predicted next PC (fetch_pc+4 when not taken)
//   upd_valid/upd_stall   : resolved instruction present / EX held (no update)
//   upd_pc, upd_uncond    : resolved PC, jal/jalr vs conditional branch
//   upd_taken, upd_target : actual outcome and target
//
// Optional build: define BTP_PERF_CNT_EN to add the 32-bit saturating
// counters perf_lookups, perf_btb_hits, perf_updates, perf_cond_mispred.
// -----------------------------------------------------------------------------
module branch_target_predictor
  import btp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 32,
  parameter int PHT_ENTRIES = 64,
  parameter int HIST_LEN    = 6,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_uncond,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_stall
`ifdef BTP_PERF_CNT_EN
  ,
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_btb_hits,
  output logic [31:0]     perf_updates,
  output logic [31:0]     perf_cond_mispred
`endif
);

  localparam int BTB_IW = idx_w(BTB_ENTRIES);
  localparam int PHT_IW = idx_w(PHT_ENTRIES);
  localparam int TAG_W  = tag_w(XLEN, BTB_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_wnt(CTR_BITS));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic             uncond;
  } entry_t;

  entry_t              btb_q [BTB_ENTRIES];
  entry_t              btb_d [BTB_ENTRIES];
  logic [CTR_BITS-1:0] pht_q [PHT_ENTRIES];
  logic [CTR_BITS-1:0] pht_d [PHT_ENTRIES];
  logic [HIST_LEN-1:0] ghr_q, ghr_d, ghr_shift;

  // ---------------------------------------------------------------- lookup
  logic [BTB_IW-1:0] f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic [PHT_IW-1:0] f_pidx;
  entry_t            f_ent;
  logic              f_hit;

  assign f_idx  = fetch_pc[BTB_IW+1:2];
  assign f_tag  = fetch_pc[XLEN-1:BTB_IW+2];
  assign f_pidx = fetch_pc[PHT_IW+1:2] ^ PHT_IW'(ghr_q);
  assign f_ent  = btb_q[f_idx];

  // Gated by reset so the outputs are clean in the reset cycle itself,
  // before the valid bits have been cleared.
  assign f_hit       = ~reset & f_ent.valid & (f_ent.tag == f_tag);
  assign pred_hit    = f_hit;
  assign pred_taken  = f_hit & (f_ent.uncond | pht_q[f_pidx][CTR_BITS-1]);
  assign pred_target = pred_taken ? f_ent.target : fetch_pc + XLEN'(4);

  // ---------------------------------------------------------------- update
  logic [BTB_IW-1:0]   u_idx;
  logic [TAG_W-1:0]    u_tag;
  logic [PHT_IW-1:0]   u_pidx;
  logic                do_upd;
  logic                cond_upd;
  logic [CTR_BITS-1:0] ctr_next;

  assign u_idx    = upd_pc[BTB_IW+1:2];
  assign u_tag    = upd_pc[XLEN-1:BTB_IW+2];
  assign u_pidx   = upd_pc[PHT_IW+1:2] ^ PHT_IW'(ghr_q);
  assign do_upd   = upd_valid & ~upd_stall;
  assign cond_upd = do_upd & ~upd_uncond;

  sat_counter #(.CTR_BITS(CTR_BITS)) u_sat_counter (
    .cur  (pht_q[u_pidx]),
    .inc  (upd_taken),
    .en   (cond_upd),
    .next (ctr_next)
  );

  generate
    if (HIST_LEN == 1) begin : g_ghr1
      assign ghr_shift = upd_taken;
    end else begin : g_ghrn
      assign ghr_shift = {ghr_q[HIST_LEN-2:0], upd_taken};
    end
  endgenerate

  always_comb begin
    btb_d = btb_q;
    pht_d = pht_q;
    ghr_d = ghr_q;
    if (do_upd && upd_taken) begin
      btb_d[u_idx] = '{valid: 1'b1, tag: u_tag, target: upd_target, uncond: upd_uncond};
    end
    if (cond_upd) begin
      pht_d[u_pidx] = ctr_next;
      ghr_d         = ghr_shift;
    end
  end

  // Only valid bits and counters need a reset value; tag/target/uncond are
  // never consulted while valid is 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_q[i].valid <= 1'b0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CTR_RST;
      ghr_q <= '0;
    end else begin
      btb_q <= btb_d;
      pht_q <= pht_d;
      ghr_q <= ghr_d;
    end
  end

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

`ifdef BTP_PERF_CNT_EN
  // ------------------------------------------------------- perf counters
  logic [31:0] lookups_q, lookups_d;
  logic [31:0] hits_q, hits_d;
  logic [31:0] updates_q, updates_d;
  logic [31:0] mispred_q, mispred_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic ev);
    return (ev && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    lookups_d = sat_inc(lookups_q, 1'b1);
    hits_d    = sat_inc(hits_q, f_hit & ~upd_stall);
    updates_d = sat_inc(updates_q, do_upd);
    mispred_d = sat_inc(mispred_q, cond_upd & (pht_q[u_pidx][CTR_BITS-1] != upd_taken));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lookups_q <= '0;
      hits_q    <= '0;
      updates_q <= '0;
      mispred_q <= '0;
    end else begin
      lookups_q <= lookups_d;
      hits_q    <= hits_d;
      updates_q <= updates_d;
      mispred_q <= mispred_d;
    end
  end

  assign perf_lookups      = lookups_q;
  assign perf_btb_hits     = hits_q;
  assign perf_updates      = updates_q;
  assign perf_cond_mispred = mispred_q;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_target_predictor
// Directed scenarios followed by randomized traffic, all outputs compared
// against a table-level reference model of the predictor.
// -----------------------------------------------------------------------------
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_uncond, upd_taken, upd_stall;
  logic [31:0] upd_pc, upd_target;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_target_predictor dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_pc    (fetch_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_uncond  (upd_uncond),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_stall   (upd_stall)
  );

  // Reference model: 32-entry BTB, 64 counters in 0..3, 6-bit history.
  bit          m_valid  [32];
  int unsigned m_tag    [32];
  int unsigned m_target [32];
  bit          m_uncond [32];
  int          m_pht    [64];
  int unsigned m_ghr;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 0;
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    m_ghr = 0;
  endfunction

  function automatic void model_predict(input int unsigned pc, input bit in_reset,
                                        output bit hit, output bit tk, output int unsigned tgt);
    int unsigned bi, pi;
    bi  = (pc / 4) % 32;
    pi  = ((pc / 4) % 64) ^ m_ghr;
    hit = !in_reset && m_valid[bi] && (m_tag[bi] == pc / 128);
    tk  = hit && (m_uncond[bi] || m_pht[pi] >= 2);
    tgt = tk ? m_target[bi] : pc + 4;
  endfunction

  function automatic void model_update(input int unsigned pc, input bit unc,
                                       input bit tk, input int unsigned tgt);
    int unsigned bi, pi;
    bi = (pc / 4) % 32;
    pi = ((pc / 4) % 64) ^ m_ghr;
    if (tk) begin
      m_valid[bi]  = 1;
      m_tag[bi]    = pc / 128;
      m_target[bi] = tgt;
      m_uncond[bi] = unc;
    end
    if (!unc) begin
      if (tk && m_pht[pi] < 3) m_pht[pi]++;
      if (!tk && m_pht[pi] > 0) m_pht[pi]--;
      m_ghr = (m_ghr * 2 + (tk ? 1 : 0)) % 64;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the model, then commit the model
  // update at the edge exactly when the design would.
  task automatic cyc(input string tag);
    bit          eh, et;
    int unsigned etg;
    #2;
    model_predict(fetch_pc, reset, eh, et, etg);
    chk({tag, ".hit"}, {31'b0, pred_hit}, {31'b0, eh});
    chk({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, et});
    chk({tag, ".target"}, pred_target, etg);
    @(posedge clk);
    if (reset) model_reset();
    else if (upd_valid && !upd_stall) model_update(upd_pc, upd_uncond, upd_taken, upd_target);
    #1;
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input bit unc,
                         input bit tk, input logic [31:0] tgt);
    upd_valid  = v;
    upd_pc     = pc;
    upd_uncond = unc;
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  initial begin
    reset     = 1'b1;
    fetch_pc  = 32'h40;
    upd_stall = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_reset();

    // Reset: outputs quiet during and after reset.
    @(posedge clk); #1;
    #2;
    chk("rst.hit", {31'b0, pred_hit}, 32'h0);
    chk("rst.taken", {31'b0, pred_taken}, 32'h0);
    chk("rst.target", pred_target, 32'h44);
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    chk("post_rst.hit", {31'b0, pred_hit}, 32'h0);
    chk("post_rst.target", pred_target, 32'h44);
    fetch_pc = 32'hFFFF_FFFC;
    #1;
    chk("wrap.target", pred_target, 32'h0);
    fetch_pc = 32'h40;
    cyc("idle0");

    // Two taken conditional updates at 0x40: counters 16,17 -> 2, GHR=3,
    // lookup uses counter 19 (still 1) so hit but not taken.
    set_upd(1'b1, 32'h40, 1'b0, 1'b1, 32'h100);
    cyc("cond1");
    cyc("cond2");
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("c40.hit", {31'b0, pred_hit}, 32'h1);
    chk("c40.taken", {31'b0, pred_taken}, 32'h0);
    chk("c40.target", pred_target, 32'h44);
    cyc("c40");

    // Unconditional jump at 0x80.
    set_upd(1'b1, 32'h80, 1'b1, 1'b1, 32'h200);
    cyc("jal80");
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    fetch_pc = 32'h80;
    #2;
    chk("j80.taken", {31'b0, pred_taken}, 32'h1);
    chk("j80.target", pred_target, 32'h200);
    cyc("j80");

    // 0xC0 aliases 0x40 (same index, different tag).
    set_upd(1'b1, 32'hC0, 1'b1, 1'b1, 32'h300);
    cyc("aliasw");
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    fetch_pc = 32'h40;
    #2;
    chk("alias40.hit", {31'b0, pred_hit}, 32'h0);
    cyc("alias40");
    fetch_pc = 32'hC0;
    #2;
    chk("aliasC0.target", pred_target, 32'h300);
    cyc("aliasC0");

    // Saturation: a run of taken branches drives GHR to all ones, after which
    // every update lands on one counter and must stop at 3.
    fetch_pc = 32'h10;
    set_upd(1'b1, 32'h10, 1'b0, 1'b1, 32'h500);
    for (int i = 0; i < 12; i++) cyc("sat_up");
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("sat_up.taken", {31'b0, pred_taken}, 32'h1);
    chk("sat_up.target", pred_target, 32'h500);
    cyc("sat_up_chk");
    set_upd(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) cyc("sat_dn");
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("sat_dn.taken", {31'b0, pred_taken}, 32'h0);
    cyc("sat_dn_chk");

    // Stalled update leaves all state alone.
    upd_stall = 1'b1;
    set_upd(1'b1, 32'h10, 1'b1, 1'b1, 32'h777);
    cyc("stall");
    upd_stall = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("stall.target", pred_target, 32'h14);
    cyc("stall_chk");

    // Same-cycle lookup and update: old contents now, new contents next cycle.
    fetch_pc = 32'h80;
    set_upd(1'b1, 32'h80, 1'b1, 1'b1, 32'h280);
    #2;
    chk("same.old", pred_target, 32'h200);
    cyc("same");
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("same.new", pred_target, 32'h280);
    cyc("same_new");

    // Reset beats a concurrent update.
    reset = 1'b1;
    set_upd(1'b1, 32'h80, 1'b1, 1'b1, 32'h999);
    cyc("rst_upd");
    reset = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("rst_upd.hit", {31'b0, pred_hit}, 32'h0);
    chk("rst_upd.target", pred_target, 32'h84);
    cyc("rst_upd_chk");

    // Randomized traffic over a small PC pool so hits, aliases and
    // counter reuse are frequent.
    for (int i = 0; i < 600; i++) begin
      fetch_pc   = ($urandom_range(0, 63) << 2) | ($urandom_range(0, 3) << 12) | $urandom_range(0, 3);
      upd_pc     = ($urandom_range(0, 63) << 2) | ($urandom_range(0, 3) << 12) | $urandom_range(0, 3);
      upd_valid  = ($urandom_range(0, 3) != 0);
      upd_stall  = ($urandom_range(0, 7) == 0);
      upd_uncond = ($urandom_range(0, 3) == 0);
      upd_taken  = upd_uncond ? 1'b1 : 1'($urandom_range(0, 1));
      upd_target = $urandom;
      reset      = ($urandom_range(0, 199) == 0);
      cyc("rand");
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
